// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file with a
//               per-register write-pending scoreboard. Register 0 reads as
//               zero, optional same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     raddr,
    output logic [NREAD*XLEN-1:0]   rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    waddr,
    input  logic [NWRITE*XLEN-1:0]  wdata,
    input  logic                    rsv_valid,
    input  logic [AW-1:0]           rsv_addr,
    output logic                    rsv_ok,
    output logic [NREGS-1:0]        pending
);

    // Entry 0 is held at zero permanently so every read path can index the
    // full address range without a special-case out-of-range slot.
    logic [XLEN-1:0]  mem_q      [NREGS];
    logic [XLEN-1:0]  mem_d      [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Per-address view of this cycle's writes: hit flag and winning data.
    logic [NREGS-1:0] w_hit;
    logic [XLEN-1:0]  w_hit_data [NREGS];

    // Resolve write ports per address; later (higher-index) ports override.
    always_comb begin
        w_hit = '0;
        for (int a = 0; a < NREGS; a++) begin
            w_hit_data[a] = '0;
        end
        for (int j = 0; j < NWRITE; j++) begin
            if (we[j]) begin
                w_hit[waddr[j*AW +: AW]]      = 1'b1;
                w_hit_data[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
        end
    end

    // A reservation is granted if the target is free, is x0, or is being
    // released by a writeback in this same cycle.
    always_comb begin
        rsv_ok = rsv_valid && !rst &&
                 ((rsv_addr == '0) || !pending_q[rsv_addr] || w_hit[rsv_addr]);
    end

    // Next-state for storage and pending bits; a same-cycle reservation wins
    // over the write's clear because the new owner supersedes the old one.
    always_comb begin
        mem_d[0]     = '0;
        pending_d    = '0;
        for (int a = 1; a < NREGS; a++) begin
            mem_d[a]     = w_hit[a] ? w_hit_data[a] : mem_q[a];
            pending_d[a] = (pending_q[a] & ~w_hit[a]) |
                           (rsv_ok && (rsv_addr == AW'(a)));
        end
    end

    // State registers with synchronous reset overriding any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            for (int a = 0; a < NREGS; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int a = 0; a < NREGS; a++) begin
                mem_q[a] <= mem_d[a];
            end
        end
    end

    assign pending = pending_q;

    // Read ports: zero for x0, bypassed write data when enabled, else storage.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = raddr[i*AW +: AW];

        // Data and busy for one read port.
        always_comb begin
            if (w_ra == '0) begin
                rdata[i*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && w_hit[w_ra]) begin
                rdata[i*XLEN +: XLEN] = w_hit_data[w_ra];
            end else begin
                rdata[i*XLEN +: XLEN] = mem_q[w_ra];
            end
            rbusy[i] = pending_q[w_ra] & ~((BYPASS != 0) & w_hit[w_ra]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp: directed vector table,
//               BYPASS=0 sequence, 64-entry sweep and randomized traffic
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: 64 regs, 4 read, 2 write, bypass on
    logic [23:0]  a_raddr;
    logic [127:0] a_rdata;
    logic [3:0]   a_rbusy;
    logic [1:0]   a_we;
    logic [11:0]  a_waddr;
    logic [63:0]  a_wdata;
    logic         rsv_valid;
    logic [5:0]   rsv_addr;
    logic         rsv_ok;
    logic [63:0]  a_pending;

    regfile_mp #(.XLEN(32), .NREGS(64), .NREAD(4), .NWRITE(2), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .pending(a_pending)
    );

    // Secondary instance: bypass off
    logic [7:0]   b_raddr;
    logic [63:0]  b_rdata;
    logic [1:0]   b_rbusy;
    logic [0:0]   b_we;
    logic [3:0]   b_waddr;
    logic [31:0]  b_wdata;
    logic         b_rv;
    logic [3:0]   b_rsv_addr;
    logic         b_ok;
    logic [15:0]  b_pending;

    regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(2), .NWRITE(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .rsv_valid(b_rv),
        .rsv_addr(b_rsv_addr), .rsv_ok(b_ok), .pending(b_pending)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of the main instance
    logic [31:0] mem_m [64];
    logic [63:0] pend_m;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Highest-index enabled write to address a (architectural collision rule)
    function automatic void whit(input logic [5:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int j = 0; j < 2; j++) begin
            if (a_we[j] && a_waddr[j*6 +: 6] == a) begin
                h = 1'b1;
                d = a_wdata[j*32 +: 32];
            end
        end
    endfunction

    // Check main-instance outputs against the model, clock once, update model
    task automatic cyc();
        logic        h;
        logic [31:0] d;
        logic [5:0]  a;
        logic        ok_e;
        logic [63:0] np;
        #1;
        for (int i = 0; i < 4; i++) begin
            a = a_raddr[i*6 +: 6];
            whit(a, h, d);
            chk("rdata", 64'(a_rdata[i*32 +: 32]),
                64'((a == 0) ? 32'd0 : (h ? d : mem_m[a])));
            chk("rbusy", 64'(a_rbusy[i]), 64'(pend_m[a] && !h));
        end
        whit(rsv_addr, h, d);
        ok_e = rsv_valid && !rst && (rsv_addr == 0 || !pend_m[rsv_addr] || h);
        chk("rsv_ok", 64'(rsv_ok), 64'(ok_e));
        chk("pending", a_pending, pend_m);
        @(posedge clk);
        if (rst) begin
            pend_m = '0;
            for (int k = 0; k < 64; k++) mem_m[k] = '0;
        end else begin
            np = pend_m;
            for (int j = 0; j < 2; j++) begin
                if (a_we[j]) begin
                    a = a_waddr[j*6 +: 6];
                    if (a != 0) mem_m[a] = a_wdata[j*32 +: 32];
                    np[a] = 1'b0;
                end
            end
            if (ok_e && rsv_addr != 0) np[rsv_addr] = 1'b1;
            np[0] = 1'b0;
            pend_m = np;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; a_we = '0; a_waddr = '0; a_wdata = '0;
        rsv_valid = 0; rsv_addr = '0; a_raddr = '0;
        b_raddr = '0; b_we = '0; b_waddr = '0; b_wdata = '0; b_rv = 0; b_rsv_addr = '0;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [5:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rv;
        logic [5:0]  ra;
        logic [5:0]  rd0;
        logic [31:0] e_rd;
        logic        e_busy;
        logic        e_ok;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //            rst we    wa0 wa1 wd0           wd1       rv ra rd0 e_rd          busy ok
        tbl[0]  = '{1'b0, 2'b01, 5, 0, 32'hDEADBEEF, 0,        1, 5, 5, 32'hDEADBEEF, 0, 1};
        tbl[1]  = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 5, 32'hDEADBEEF, 1, 0};
        tbl[2]  = '{1'b1, 2'b01, 5, 0, 32'h55,       0,        1, 6, 5, 32'h55,       0, 0};
        tbl[3]  = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 5, 32'h0,        0, 0};
        tbl[4]  = '{1'b0, 2'b01, 0, 0, 32'h1234,     0,        1, 0, 0, 32'h0,        0, 1};
        tbl[5]  = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 0, 32'h0,        0, 0};
        tbl[6]  = '{1'b0, 2'b01, 3, 0, 32'hA5A5A5A5, 0,        0, 0, 3, 32'hA5A5A5A5, 0, 0};
        tbl[7]  = '{1'b0, 2'b11, 7, 7, 32'h11,       32'h22,   0, 0, 7, 32'h22,       0, 0};
        tbl[8]  = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 7, 32'h22,       0, 0};
        tbl[9]  = '{1'b0, 2'b00, 0, 0, 0,            0,        1, 9, 9, 32'h0,        0, 1};
        tbl[10] = '{1'b0, 2'b00, 0, 0, 0,            0,        1, 9, 9, 32'h0,        1, 0};
        tbl[11] = '{1'b0, 2'b01, 9, 0, 32'h99,       0,        1, 9, 9, 32'h99,       0, 1};
        tbl[12] = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 9, 32'h99,       1, 0};
        tbl[13] = '{1'b0, 2'b10, 0, 9, 0,            32'h77,   0, 0, 9, 32'h77,       0, 0};
        tbl[14] = '{1'b0, 2'b00, 0, 0, 0,            0,        0, 0, 9, 32'h77,       0, 0};

        idle();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pend_m = '0;
        for (int k = 0; k < 64; k++) mem_m[k] = '0;
        cyc();
        rst = 0;

        // Directed table
        for (int t = 0; t < 15; t++) begin
            rst = tbl[t].rst; a_we = tbl[t].we;
            a_waddr = {tbl[t].wa1, tbl[t].wa0};
            a_wdata = {tbl[t].wd1, tbl[t].wd0};
            rsv_valid = tbl[t].rv; rsv_addr = tbl[t].ra;
            a_raddr = {6'd7, 6'd9, 6'd5, tbl[t].rd0};
            #1;
            chk($sformatf("vec%0d_rdata", t), 64'(a_rdata[31:0]), 64'(tbl[t].e_rd));
            chk($sformatf("vec%0d_rbusy", t), 64'(a_rbusy[0]), 64'(tbl[t].e_busy));
            chk($sformatf("vec%0d_rsv_ok", t), 64'(rsv_ok), 64'(tbl[t].e_ok));
            cyc();
        end
        idle();

        // BYPASS=0 instance: old value on write cycle, raw busy bit
        b_we = 1'b1; b_waddr = 4'd3; b_wdata = 32'hA5A5A5A5; b_raddr = {4'd0, 4'd3};
        #1;
        chk("nobyp_old", 64'(b_rdata[31:0]), 64'h0);
        cyc();
        b_we = 1'b0; b_rv = 1'b1; b_rsv_addr = 4'd4; b_raddr = {4'd4, 4'd3};
        #1;
        chk("nobyp_new", 64'(b_rdata[31:0]), 64'hA5A5A5A5);
        chk("nobyp_rsv", 64'(b_ok), 64'h1);
        cyc();
        b_rv = 1'b0; b_we = 1'b1; b_waddr = 4'd4; b_wdata = 32'h44;
        #1;
        chk("nobyp_busy_raw", 64'(b_rbusy[1]), 64'h1);
        chk("nobyp_rd_old", 64'(b_rdata[63:32]), 64'h0);
        cyc();
        b_we = 1'b0;
        #1;
        chk("nobyp_busy_clr", 64'(b_rbusy[1]), 64'h0);
        chk("nobyp_rd_new", 64'(b_rdata[63:32]), 64'h44);
        chk("nobyp_pending", 64'(b_pending), 64'h0);
        cyc();

        // Sweep: write k*3 to every register, read all back four per cycle
        for (int k = 1; k < 64; k += 2) begin
            a_we = (k + 1 < 64) ? 2'b11 : 2'b01;
            a_waddr = {6'(k + 1), 6'(k)};
            a_wdata = {32'((k + 1) * 3), 32'(k * 3)};
            cyc();
        end
        a_we = '0;
        for (int base = 0; base < 64; base += 4) begin
            a_raddr = {6'(base + 3), 6'(base + 2), 6'(base + 1), 6'(base)};
            #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sweep_r%0d", base + i), 64'(a_rdata[i*32 +: 32]),
                    64'((base + i) * 3));
            end
            cyc();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            a_we = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                a_waddr[j*6 +: 6] = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom);
                a_wdata[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 4; i++) begin
                a_raddr[i*6 +: 6] = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            end
            rsv_valid = 1'($urandom);
            rsv_addr  = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
